// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - RV32I major opcodes (OP_*)
//   - fmt_e   : immediate format selected by opcode
//   - state_e : occupancy of the output register + skid buffer
//   - dbg_t   : debug bundle exposing FSM state and decoded format
//   - is_legal_op : opcode legality check used when DECODE_ILLEGAL_EN is defined
package decode_pkg;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // Encoding chosen so that bit 1 alone marks FULL: in_ready is then
  // simply the inverse of one flop bit.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  typedef struct packed {
    state_e state;
    fmt_e   fmt;
  } dbg_t;

  // Every legal RV32I opcode has insn[1:0]==2'b11, so matching the full
  // 7-bit opcode also covers the compressed-encoding check.
  function automatic logic is_legal_op(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
      OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// imm_gen: purely combinational immediate generator.
//   insn_i : 32-bit instruction word
//   fmt_o  : immediate format implied by the opcode
//   imm_o  : sign-extended (or U-type shifted) 32-bit immediate; 0 for R/other
module imm_gen
  import decode_pkg::*;
(
  input  logic [31:0] insn_i,
  output fmt_e        fmt_o,
  output logic [31:0] imm_o
);

  always_comb begin
    fmt_o = FMT_R;
    case (insn_i[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: fmt_o = FMT_I;
      OP_STORE:                            fmt_o = FMT_S;
      OP_BRANCH:                           fmt_o = FMT_B;
      OP_LUI, OP_AUIPC:                    fmt_o = FMT_U;
      OP_JAL:                              fmt_o = FMT_J;
      default:                             fmt_o = FMT_R;
    endcase
  end

  always_comb begin
    imm_o = '0;
    case (fmt_o)
      FMT_I: imm_o = {{20{insn_i[31]}}, insn_i[31:20]};
      FMT_S: imm_o = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
      FMT_B: imm_o = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                      insn_i[30:25], insn_i[11:8], 1'b0};
      FMT_U: imm_o = {insn_i[31:12], 12'b0};
      FMT_J: imm_o = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                      insn_i[20], insn_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// decode: RV32I decode stage with registered output and one-entry skid buffer.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1 (in_fire = in_valid_i & in_ready_o, out_fire = out_valid_o &
// out_ready_i). Once out_valid_o is raised, every output stays bit-stable
// until out_fire. in_ready_o depends only on registered state.
//
// Ports:
//   clk, rst          : clock; synchronous active-low reset
//   pc_i, insn_i      : incoming instruction from fetch
//   in_valid_i/in_ready_o : fetch-side handshake
//   flush_i           : drop everything held (redirect); same-cycle input lost
//   out_valid_o/out_ready_i : execute-side handshake
//   pc_o, insn_o      : held pc / instruction
//   opcode_o..funct7_o: RV32I fields of insn_o
//   imm_o             : immediate of insn_o
//   illegal_o         : only with DECODE_ILLEGAL_EN; unknown opcode, qualified
//                       by out_valid_o
//   dbg_o             : FSM state and decoded immediate format
//
// Optional feature macro: DECODE_ILLEGAL_EN
module decode
  import decode_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] insn_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              flush_i,
  input  logic              out_ready_i,
  output logic              out_valid_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] insn_o,
  output logic [6:0]        opcode_o,
  output logic [4:0]        rd_o,
  output logic [2:0]        funct3_o,
  output logic [4:0]        rs1_o,
  output logic [4:0]        rs2_o,
  output logic [6:0]        funct7_o,
`ifdef DECODE_ILLEGAL_EN
  output logic              illegal_o,
`endif
  output logic [31:0]       imm_o,
  output dbg_t              dbg_o
);

  state_e            state_q, state_d;
  logic [AWIDTH-1:0] out_pc_q, out_pc_d;
  logic [DWIDTH-1:0] out_insn_q, out_insn_d;
  logic [AWIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [DWIDTH-1:0] skid_insn_q, skid_insn_d;
  logic              in_fire, out_fire;
  fmt_e              fmt;

  assign in_ready_o  = ~state_q[1];
  assign out_valid_o = (state_q != EMPTY);
  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;

  always_comb begin
    state_d     = state_q;
    out_pc_d    = out_pc_q;
    out_insn_d  = out_insn_q;
    skid_pc_d   = skid_pc_q;
    skid_insn_d = skid_insn_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d    = BUSY;
          out_pc_d   = pc_i;
          out_insn_d = insn_i;
        end
      end
      BUSY: begin
        if (in_fire && !out_fire) begin
          state_d     = FULL;
          skid_pc_d   = pc_i;
          skid_insn_d = insn_i;
        end else if (!in_fire && out_fire) begin
          state_d = EMPTY;
        end else if (in_fire && out_fire) begin
          out_pc_d   = pc_i;
          out_insn_d = insn_i;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d    = BUSY;
          out_pc_d   = skid_pc_q;
          out_insn_d = skid_insn_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Held data may stay in the registers; out_valid_o=0 marks it dead.
    if (flush_i) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= EMPTY;
      out_pc_q    <= '0;
      out_insn_q  <= '0;
      skid_pc_q   <= '0;
      skid_insn_q <= '0;
    end else begin
      state_q     <= state_d;
      out_pc_q    <= out_pc_d;
      out_insn_q  <= out_insn_d;
      skid_pc_q   <= skid_pc_d;
      skid_insn_q <= skid_insn_d;
    end
  end

  assign pc_o     = out_pc_q;
  assign insn_o   = out_insn_q;
  assign opcode_o = out_insn_q[6:0];
  assign rd_o     = out_insn_q[11:7];
  assign funct3_o = out_insn_q[14:12];
  assign rs1_o    = out_insn_q[19:15];
  assign rs2_o    = out_insn_q[24:20];
  assign funct7_o = out_insn_q[31:25];

  imm_gen u_imm_gen (
    .insn_i (out_insn_q[31:0]),
    .fmt_o  (fmt),
    .imm_o  (imm_o)
  );

`ifdef DECODE_ILLEGAL_EN
  // Gated by out_valid_o so the reset value (insn=0) reads as legal.
  assign illegal_o = out_valid_o & ~is_legal_op(out_insn_q[6:0]);
`endif

  assign dbg_o = '{state: state_q, fmt: fmt};

endmodule
